// File: rtl/up_counter_mod_if.sv
// Counter control/status bundle: the master drives en/load/load_val/clr_wrap, the counter
// (slave) returns counter/tc/wrap_flag.
interface up_counter_mod_if #(
  parameter int unsigned WIDTH = 4
);
  logic             en;
  logic             load;
  logic [WIDTH-1:0] load_val;
  logic             clr_wrap;
  logic [WIDTH-1:0] counter;
  logic             tc;
  logic             wrap_flag;

  modport master (
    output en, load, load_val, clr_wrap,
    input  counter, tc, wrap_flag
  );

  modport slave (
    input  en, load, load_val, clr_wrap,
    output counter, tc, wrap_flag
  );
endinterface

// File: rtl/up_counter_mod.sv
// Modulo-MODULUS up counter with parallel load, cascadable terminal count and an optional
// sticky wrap flag built only when UP_COUNTER_WRAP_FLAG_EN is defined.
module up_counter_mod #(
  parameter int unsigned WIDTH   = 4,
  parameter int unsigned MODULUS = 16
) (
  input logic              clk,
  input logic              reset,
  up_counter_mod_if.slave  bus
);

  // MODULUS may equal 2^WIDTH, so compare against MODULUS-1 to stay within WIDTH bits.
  localparam logic [WIDTH-1:0] MaxCount = WIDTH'(MODULUS - 1);

  logic [WIDTH-1:0] counter_d, counter_q;
  logic             at_max;
  logic             tc;

  always_comb begin
    at_max    = (counter_q == MaxCount);
    tc        = at_max & bus.en & ~bus.load;
    counter_d = counter_q;
    if (bus.load) begin
      counter_d = (bus.load_val > MaxCount) ? '0 : bus.load_val;
    end else if (bus.en) begin
      counter_d = at_max ? '0 : counter_q + WIDTH'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      counter_q <= '0;
    end else begin
      counter_q <= counter_d;
    end
  end

  assign bus.counter = counter_q;
  assign bus.tc      = tc;

`ifdef UP_COUNTER_WRAP_FLAG_EN
  logic wrap_d, wrap_q;

  // Set has priority over clear when a wrap coincides with clr_wrap.
  always_comb begin
    wrap_d = wrap_q;
    if (tc) begin
      wrap_d = 1'b1;
    end else if (bus.clr_wrap) begin
      wrap_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wrap_q <= 1'b0;
    end else begin
      wrap_q <= wrap_d;
    end
  end

  assign bus.wrap_flag = wrap_q;
`else
  logic unused_clr_wrap;
  assign unused_clr_wrap = bus.clr_wrap;
  assign bus.wrap_flag   = 1'b0;
`endif

endmodule

// File: doc/up_counter_mod.md
UP_COUNTER_MOD -- requirements
Module: up_counter_mod

Interface
REQ-001 The block SHALL have parameter WIDTH, default 4, giving the counter width in bits.
REQ-002 The block SHALL have parameter MODULUS, default 16, giving the count range 0..MODULUS-1, with legal values 2..2^WIDTH.
REQ-003 The block SHALL have port clk, input, 1 bit, the single clock; all state SHALL update on its rising edge.
REQ-004 The block SHALL have port reset, input, 1 bit, an asynchronous active-high reset.
REQ-005 The block SHALL have port en, input, 1 bit, the count enable.
REQ-006 The block SHALL have port load, input, 1 bit, a synchronous parallel-load strobe.
REQ-007 The block SHALL have port load_val, input, WIDTH bits, the value to load.
REQ-008 The block SHALL have port clr_wrap, input, 1 bit, which clears the sticky wrap flag.
REQ-009 The block SHALL have port counter, output, WIDTH bits, the current count, driven directly from a register.
REQ-010 The block SHALL have port tc, output, 1 bit, the terminal-count/carry-out signal, combinational.
REQ-011 The block SHALL have port wrap_flag, output, 1 bit, the sticky wrap indicator, driven from a register.

Function
REQ-012 Priority per rising edge SHALL be: load, then en, then hold.
REQ-013 When load=1, counter SHALL take load_val on the next edge.
REQ-014 When load=1 and load_val >= MODULUS, counter SHALL take 0 instead of load_val.
REQ-015 When load=0, en=1 and counter < MODULUS-1, counter SHALL increment by 1 on the next edge.
REQ-016 When load=0, en=1 and counter = MODULUS-1, counter SHALL wrap to 0 on the next edge.
REQ-017 When load=0 and en=0, counter SHALL hold its value.
REQ-018 Arithmetic SHALL be unsigned, modulo MODULUS, and no intermediate value SHALL exceed WIDTH bits.
REQ-019 tc SHALL equal (counter = MODULUS-1) AND en AND NOT load, allowing cascading: tc of one stage drives en of the next stage.
REQ-020 A wrap event SHALL be defined as the cycle in which tc=1.
REQ-021 Count latency SHALL be one clock from en or load to the updated counter value.

Reset
REQ-022 While reset=1, counter SHALL be 0 and wrap_flag SHALL be 0, independent of clk.
REQ-023 Reset asserted mid-count SHALL clear state immediately, and the first edge after deassertion SHALL act on the inputs from 0.
REQ-024 tc SHALL be 0 during reset because counter=0, except when MODULUS-1=0, which REQ-002 excludes.

Configuration
REQ-025 The macro UP_COUNTER_WRAP_FLAG_EN SHALL select whether the sticky wrap flag is built.
REQ-026 With UP_COUNTER_WRAP_FLAG_EN defined, wrap_flag SHALL set to 1 on the edge ending a wrap-event cycle, hold until clr_wrap=1 clears it on the next edge, and set SHALL win when set and clear coincide.
REQ-027 With UP_COUNTER_WRAP_FLAG_EN undefined, wrap_flag SHALL be constant 0, clr_wrap SHALL be ignored, and no flag register SHALL be inferred.
REQ-028 All other behaviour SHALL be identical with and without UP_COUNTER_WRAP_FLAG_EN.

Verification
REQ-029 Scenario: default parameters, reset, then en=1 for 17 clocks -> counter steps 0,1,...,15,0,1; tc=1 only while counter=15; wrap_flag=1 from the edge after 15 (when the macro is defined).
REQ-030 Scenario: MODULUS=10, en=1 -> counter steps 0..9,0; tc=1 at 9; load_val=12 with load=1 -> counter=0.
REQ-031 Scenario: counter=7, load=1, load_val=3, en=1 on the same cycle -> counter=3, which shows load priority; with en=0 the counter holds at 3.
REQ-032 Scenario: reset asserted asynchronously between edges at counter=9 -> counter=0 and wrap_flag=0 immediately; counting resumes 0,1 after release.
REQ-033 Scenario: wrap_flag=1, then clr_wrap=1 coinciding with a wrap event -> wrap_flag stays 1; clr_wrap=1 alone -> wrap_flag=0 on the next edge; with the macro undefined, wrap_flag is 0 throughout.
REQ-034 Scenario: two instances cascaded (tc0 drives en1), en0=1 for 256 clocks -> the pair counts 0x00..0xFF and back to 0x00; tc1=1 only at 0xFF.
